// File: rtl/sram_pkg.sv
// Shared constants, init FSM state type and mask helper for the parametrised 1R1W SRAM.
package sram_pkg;

    localparam int unsigned RDW_OLD        = 0;
    localparam int unsigned RDW_NEW        = 1;
    localparam int unsigned RD_LAT_MIN     = 1;
    localparam int unsigned RD_LAT_MAX     = 2;
    localparam int unsigned MAX_DATA_WIDTH = 256;

    typedef enum logic [1:0] {
        INIT_IDLE,
        INIT_SWEEP,
        INIT_DONE
    } init_state_e;

    // Widen a lane mask to one bit per data bit; callers truncate to their width.
    function automatic logic [MAX_DATA_WIDTH-1:0] expand_mask(
        input logic [MAX_DATA_WIDTH-1:0] mask,
        input int unsigned               gran
    );
        logic [MAX_DATA_WIDTH-1:0] bits;
        logic [MAX_DATA_WIDTH-1:0] sel;
        bits = '0;
        if (gran != 0) begin
            for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
                sel     = mask >> (i / gran);
                bits[i] = sel[0];
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/sram_init_sweeper.sv
// Post-reset init sweep: walks every word once, then raises ready.
module sram_init_sweeper
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned INIT_EN    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  sweep_en,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    init_state_e           state;
    logic [ADDR_WIDTH-1:0] counter;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (INIT_EN != 0) ? INIT_SWEEP : INIT_DONE;
            counter <= '0;
            ready   <= (INIT_EN == 0);
        end else begin
            case (state)
                INIT_IDLE: begin
                    counter <= '0;
                    state   <= (INIT_EN != 0) ? INIT_SWEEP : INIT_DONE;
                end
                INIT_SWEEP: begin
                    counter <= counter + 1'b1;
                    if (counter == LAST_ADDR) begin
                        state   <= INIT_DONE;
                        counter <= '0;
                        ready   <= 1'b1;
                    end
                end
                INIT_DONE: begin
                    ready <= 1'b1;
                end
                default: state <= INIT_DONE;
            endcase
        end
    end

    assign sweep_en   = (state == INIT_SWEEP);
    assign sweep_addr = counter;

endmodule

// File: rtl/sram_1r1w_param_ext.sv
// Parametrised 1R1W behavioural SRAM with masked writes, init sweep,
// configurable read latency and read-during-write semantics.
module sram_1r1w_param_ext #(
    parameter int unsigned           DATA_WIDTH   = 64,
    parameter int unsigned           ADDR_WIDTH   = 9,
    parameter int unsigned           DEPTH        = 512,
    parameter int unsigned           MASK_GRAN    = 8,
    parameter int unsigned           READ_LATENCY = 1,
    parameter int unsigned           RDW_NEW      = 0,
    parameter int unsigned           INIT_EN      = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    localparam int unsigned          MASK_WIDTH   = DATA_WIDTH / MASK_GRAN
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  W0_en,
    input  logic [ADDR_WIDTH-1:0] W0_addr,
    input  logic [DATA_WIDTH-1:0] W0_data,
    input  logic [MASK_WIDTH-1:0] W0_mask,
    input  logic                  R0_en,
    input  logic [ADDR_WIDTH-1:0] R0_addr,
    output logic [DATA_WIDTH-1:0] R0_data,
    output logic                  R0_valid,
    output logic                  ready
);

    import sram_pkg::*;

    if (DATA_WIDTH % MASK_GRAN != 0) begin : g_err_gran
        $error("DATA_WIDTH must be a multiple of MASK_GRAN");
    end
    if (DEPTH < 1 || 64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_err_depth
        $error("DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH");
    end
    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_err_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_err_width
        $error("DATA_WIDTH exceeds mask helper width");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep_en;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    sram_init_sweeper #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_EN    (INIT_EN)
    ) u_sweeper (
        .clock      (clock),
        .reset_n    (reset_n),
        .sweep_en   (sweep_en),
        .sweep_addr (sweep_addr),
        .ready      (ready)
    );

    logic                  w_acc;
    logic                  r_acc;
    logic                  r_in_range;
    logic [DATA_WIDTH-1:0] w_bits;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_data;
    logic [DATA_WIDTH-1:0] arr_bits;

    assign w_acc      = ready && W0_en && ({1'b0, W0_addr} < DEPTH_W);
    assign r_acc      = ready && R0_en;
    assign r_in_range = {1'b0, R0_addr} < DEPTH_W;
    assign w_bits     = DATA_WIDTH'(expand_mask(MAX_DATA_WIDTH'(W0_mask), MASK_GRAN));

    // Sweep owns the write port until ready; user writes are gated off by w_acc.
    always_comb begin
        arr_we   = sweep_en || w_acc;
        arr_addr = sweep_en ? sweep_addr : W0_addr;
        arr_data = sweep_en ? INIT_VALUE : W0_data;
        arr_bits = sweep_en ? '1 : w_bits;
    end

    always_ff @(posedge clock) begin
        if (arr_we) begin
            mem[arr_addr] <= (mem[arr_addr] & ~arr_bits) | (arr_data & arr_bits);
        end
    end

    always_comb begin
        rd_old  = r_in_range ? mem[R0_addr] : '0;
        rd_word = rd_old;
        if (RDW_NEW == sram_pkg::RDW_NEW && w_acc && W0_addr == R0_addr) begin
            rd_word = (rd_old & ~w_bits) | (W0_data & w_bits);
        end
    end

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  p_valid;
        logic [DATA_WIDTH-1:0] p_data;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                p_valid <= 1'b0;
                p_data  <= '0;
            end else begin
                p_valid <= r_acc;
                if (r_acc) p_data <= rd_word;
            end
        end

        assign out_valid = p_valid;
        assign out_data  = p_data;
    end else begin : g_lat1
        assign out_valid = r_acc;
        assign out_data  = rd_word;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            R0_valid <= 1'b0;
            R0_data  <= '0;
        end else begin
            R0_valid <= out_valid;
            if (out_valid) R0_data <= out_data;
        end
    end

endmodule

// File: tb/tb_sram_1r1w_param_ext.sv
// Bench for sram_1r1w_param_ext: two configurations driven in lockstep against an array model.
module tb_sram_1r1w_param_ext;

    localparam logic [63:0] INIT_V = 64'hDEAD_BEEF_0000_0001;
    localparam int          DEP [2] = '{512, 300};
    localparam int          LAT [2] = '{1, 2};
    localparam int          RDWN[2] = '{0, 1};

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        w_en = 1'b0;
    logic [8:0]  w_addr = '0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_mask = '0;
    logic        r_en = 1'b0;
    logic [8:0]  r_addr = '0;

    logic [63:0] r_data_a, r_data_b;
    logic        r_valid_a, r_valid_b, rdy_a, rdy_b;

    always #5 clock = ~clock;

    sram_1r1w_param_ext #(
        .INIT_VALUE (INIT_V)
    ) u_dut_a (
        .clock (clock), .reset_n (reset_n),
        .W0_en (w_en), .W0_addr (w_addr), .W0_data (w_data), .W0_mask (w_mask),
        .R0_en (r_en), .R0_addr (r_addr),
        .R0_data (r_data_a), .R0_valid (r_valid_a), .ready (rdy_a)
    );

    sram_1r1w_param_ext #(
        .DEPTH        (300),
        .READ_LATENCY (2),
        .RDW_NEW      (1),
        .INIT_VALUE   (INIT_V)
    ) u_dut_b (
        .clock (clock), .reset_n (reset_n),
        .W0_en (w_en), .W0_addr (w_addr), .W0_data (w_data), .W0_mask (w_mask),
        .R0_en (r_en), .R0_addr (r_addr),
        .R0_data (r_data_b), .R0_valid (r_valid_b), .ready (rdy_b)
    );

    typedef struct {
        int          due;
        logic [63:0] d;
    } rd_t;

    logic [63:0] mem_m [2][512];
    logic [63:0] hold  [2];
    rd_t         q0[$];
    rd_t         q1[$];
    int          edge_cnt = 0;
    int          since_rel = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic void model_edge(input int d);
        logic [63:0] rv;
        rd_t         e;
        if (since_rel < DEP[d]) return;
        if (r_en) begin
            if (int'(r_addr) >= DEP[d]) rv = '0;
            else begin
                rv = mem_m[d][r_addr];
                if (RDWN[d] != 0 && w_en && w_addr == r_addr) rv = merge(rv, w_data, w_mask);
            end
            e.due = edge_cnt + LAT[d];
            e.d   = rv;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (w_en && int'(w_addr) < DEP[d])
            mem_m[d][w_addr] = merge(mem_m[d][w_addr], w_data, w_mask);
    endfunction

    task automatic check_dut(input int d, input logic v, input logic [63:0] dat, input logic rdy);
        logic exp_v;
        exp_v = 1'b0;
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].due == edge_cnt) begin
                exp_v = 1'b1; hold[0] = q0[0].d; void'(q0.pop_front());
            end
        end else begin
            if (q1.size() > 0 && q1[0].due == edge_cnt) begin
                exp_v = 1'b1; hold[1] = q1[0].d; void'(q1.pop_front());
            end
        end
        check($sformatf("%s.valid@%0d", d == 0 ? "a" : "b", edge_cnt), 64'(v), 64'(exp_v));
        check($sformatf("%s.data@%0d",  d == 0 ? "a" : "b", edge_cnt), dat, hold[d]);
        check($sformatf("%s.ready@%0d", d == 0 ? "a" : "b", edge_cnt), 64'(rdy),
              64'(since_rel >= DEP[d]));
    endtask

    task automatic cycle();
        if (reset_n) begin
            model_edge(0);
            model_edge(1);
        end
        @(posedge clock);
        edge_cnt++;
        if (reset_n) since_rel++;
        @(negedge clock);
        check_dut(0, r_valid_a, r_data_a, rdy_a);
        check_dut(1, r_valid_b, r_data_b, rdy_b);
    endtask

    task automatic req(input logic we, input int wa, input logic [63:0] wd, input logic [7:0] wm,
                       input logic re, input int ra);
        w_en = we; w_addr = 9'(wa); w_data = wd; w_mask = wm;
        r_en = re; r_addr = 9'(ra);
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) req(1'b0, 0, '0, '0, 1'b0, 0);
    endtask

    task automatic rand_req();
        int wa, ra;
        wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15));
        ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) ra = wa;
        req(1'($urandom), wa, {$urandom, $urandom}, 8'($urandom), 1'($urandom), ra);
    endtask

    task automatic do_reset(input int cycles);
        reset_n   = 1'b0;
        since_rel = 0;
        hold[0]   = '0;
        hold[1]   = '0;
        q0.delete();
        q1.delete();
        repeat (cycles) rand_req();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 512; i++) mem_m[d][i] = INIT_V;
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [63:0] v3;

        @(negedge clock);
        do_reset(3);

        // Abort the sweep when its counter reaches 100; requests meanwhile must be ignored.
        repeat (100) rand_req();
        do_reset(2);

        n = 0;
        while (!rdy_a && n < 600) begin
            rand_req();
            n++;
        end
        check("ready_latency_a", 64'(n), 64'd512);

        foreach (DEP[i]) begin
            req(1'b0, 0, '0, '0, 1'b1, i == 0 ? 0 : 255);
            idle(2);
        end
        check("t1_addr0_a", r_data_a, INIT_V);
        req(1'b0, 0, '0, '0, 1'b1, 511);
        idle(2);
        check("t1_addr511_a", r_data_a, INIT_V);
        check("t1_addr511_oor_b", r_data_b, 64'h0);

        for (int i = 0; i < 512; i++) req(1'b0, 0, '0, '0, 1'b1, i);
        idle(2);

        req(1'b1, 5, 64'h1122334455667788, 8'hFF, 1'b0, 0);
        req(1'b1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 0);
        req(1'b0, 0, '0, '0, 1'b1, 5);
        idle(2);
        check("t2_merge_a", r_data_a, 64'h11223344AAAAAAAA);
        check("t2_merge_b", r_data_b, 64'h11223344AAAAAAAA);

        req(1'b1, 7, 64'h0, 8'hFF, 1'b0, 0);
        req(1'b1, 7, 64'hFF, 8'h01, 1'b1, 7);
        idle(2);
        check("t3_rdw_old_a", r_data_a, 64'h0);
        check("t3_rdw_new_b", r_data_b, 64'hFF);
        req(1'b0, 0, '0, '0, 1'b1, 7);
        idle(2);
        check("t3_after_a", r_data_a, 64'hFF);
        check("t3_after_b", r_data_b, 64'hFF);

        for (int i = 1; i <= 3; i++) req(1'b1, i, 64'h1111 * i, 8'hFF, 1'b0, 0);
        for (int i = 1; i <= 3; i++) req(1'b0, 0, '0, '0, 1'b1, i);
        idle(3);
        v3 = 64'h3333;
        check("t4_hold_b", r_data_b, v3);
        check("t4_valid_low_b", 64'(r_valid_b), 64'd0);

        req(1'b1, 400, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 1'b0, 0);
        req(1'b0, 0, '0, '0, 1'b1, 400);
        idle(2);
        check("t5_oor_read_b", r_data_b, 64'h0);
        req(1'b0, 0, '0, '0, 1'b1, 144);
        idle(2);
        check("t5_alias_b", r_data_b, INIT_V);

        repeat (3000) rand_req();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
